sgpr_rd_port_arbiter: RTL and testbench
=======================================

# sgpr_rd_port_arbiter

Shares the single SGPR read port among three requesters: port 0, port 1 and port 2. Each cycle it selects at most one pending request, issues the read address to the SGPR array from a register, and steers the returned 128-bit data back to the winner with a one-cycle valid pulse. It replaces the "exactly one enable high" contract with a real request/grant handshake, so requesters may contend freely.

## Interface
Parameters
- ADDR_W, 9: SGPR read address width.
- DATA_W, 128: read data width (4 × 32-bit SGPRs).

Ports
- clk  in  1  single clock; everything is on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- portN_rd_req  in  1  (N = 0,1,2) read request; held high until granted.
- portN_rd_addr  in  ADDR_W  read address; stable while the request is high.
- portN_rd_gnt  out  1  combinational grant; the request is accepted in this cycle.
- portN_rd_valid  out  1  registered; `port_rd_data` belongs to port N this cycle.
- port_rd_data  out  DATA_W  shared return bus; equal to `rd_data`.
- rd_en  out  1  registered read strobe to the SGPR array.
- rd_addr  out  ADDR_W  registered read address to the SGPR array.
- rd_data  in  DATA_W  array read data, valid one cycle after `rd_en`.

## Operation
- **Request capture.** A request is accepted in the cycle where `portN_rd_req` and `portN_rd_gnt` are both high.
  - The requester may drop `req`, or present a new address with `req` still high, in the next cycle.
  - Back-to-back grants to the same port are legal.
- **Grant rules.** At most one grant is high per cycle.
  - A grant is issued in any cycle with at least one request.
  - Grants are 0 while `rst_n` is low.
- **Round-robin arbitration** (with `SGPR_RD_ARB_RR_EN`, see Configuration).
  - A 2-bit `last_gnt` register holds the most recently granted port.
  - Priority order is `last_gnt+1`, `last_gnt+2`, `last_gnt`, taken mod 3 (3 wraps to 0).
  - `last_gnt` updates only in cycles that contain a grant.
  - Reset value of `last_gnt` is 2, so port 0 has first priority.
- **Issue.** On a grant, at the next edge: `rd_en` ← 1, `rd_addr` ← the winner's address, `id_q` ← the winner's index.
  - In a cycle with no grant: `rd_en` ← 0, and `rd_addr` holds its value.
- **Return.** One cycle after `rd_en`, exactly one `portN_rd_valid` pulses for one cycle, selected by a second-stage `id_q2` register.
  - Valid pulses come out in grant order.
- **Throughput.** One read per cycle; no internal queue; no backpressure from the array.
- **Reset values.**
  - `rd_en` 0, `rd_addr` 0, all `portN_rd_valid` 0.
  - `last_gnt` 2; the id pipeline registers are 0.
- **Reset mid-operation.** In-flight reads are dropped and no valid pulses follow.
  - Requests held through reset are arbitrated fresh once `rst_n` rises, starting from port 0 priority.

## Timing
- Cycle T: request high, grant combinational in T.
- T+1: `rd_en` and `rd_addr` presented to the array.
- T+2: `rd_data` from the array, `portN_rd_valid` high, `port_rd_data` valid.
- Total latency: 2 cycles from grant to data, for every port, independent of contention.
- Grant logic depends only on the current `req` inputs and `last_gnt`; there is no combinational path from `rd_data`.

## Configuration
- **`SGPR_RD_ARB_RR_EN` defined:** round-robin arbitration as described in Operation.
- **`SGPR_RD_ARB_RR_EN` undefined:** fixed priority, port 0 > port 1 > port 2.
  - The `last_gnt` register is removed.
  - Port latency and all other behaviour are unchanged.

## Structure
- **Shared package `sgpr_rd_arb_pkg`:**
  - `NUM_RD_PORTS` = 3.
  - `SGPR_ADDR_W` = 9.
  - `SGPR_DATA_W` = 128.
  - Typedef `rd_port_id_t` (2 bits) with constants `RD_PORT0` = 0, `RD_PORT1` = 1, `RD_PORT2` = 2.
- **Sub-module `sgpr_rr_pick3`:** combinational 3-way picker.
  - Inputs: 3-bit request vector, 2-bit last index.
  - Outputs: one-hot grant, 2-bit winner index.
  - Fixed-priority mode ties the last index to 2.
- The top level holds the issue registers, the 2-stage id pipeline and the valid decode.

## Test plan
- **Reset values:** assert `rst_n` = 0 with all requests high -> all grants 0, `rd_en` 0, `rd_addr` 0, all valids 0; after release, the first grant goes to port 0.
- **Single port:** port1 requests addr 0x05A for one cycle -> `port1_rd_gnt` in T, `rd_en` = 1 / `rd_addr` = 0x05A at T+1, `port1_rd_valid` = 1 at T+2 with `port_rd_data` = `rd_data`.
- **Full contention (RR):** all three requests held high for 6 cycles -> grant order 0,1,2,0,1,2; valids follow 2 cycles later in the same order; never two grants in one cycle.
- **Full contention (fixed priority):** same stimulus with the macro undefined -> port 0 granted every cycle; ports 1 and 2 are granted only after port 0 drops its request.
- **Back-to-back same port:** port2 alone changes address each cycle 0x010, 0x011, 0x012 -> `rd_addr` 0x010, 0x011, 0x012 on consecutive cycles; three consecutive `port2_rd_valid` pulses.
- **Reset mid-flight:** grant to port0, then `rst_n` = 0 at T+1 -> no `port0_rd_valid` at T+2; `rd_en` = 0 immediately.

Source files
------------

// File: rtl/sgpr_rd_arb_pkg.sv
// Shared types and constants for the SGPR read-port arbiter.
// The only build option is SGPR_RD_ARB_RR_EN, used by sgpr_rd_port_arbiter.
package sgpr_rd_arb_pkg;

    localparam int NUM_RD_PORTS = 3;
    localparam int SGPR_ADDR_W  = 9;
    localparam int SGPR_DATA_W  = 128;

    typedef logic [1:0] rd_port_id_t;

    localparam rd_port_id_t RD_PORT0 = 2'd0;
    localparam rd_port_id_t RD_PORT1 = 2'd1;
    localparam rd_port_id_t RD_PORT2 = 2'd2;

    // Next port index in mod-3 order; the unused encoding 3 folds to port 0.
    function automatic rd_port_id_t rd_port_inc(input rd_port_id_t id);
        rd_port_id_t nxt;
        case (id)
            RD_PORT0: nxt = RD_PORT1;
            RD_PORT1: nxt = RD_PORT2;
            RD_PORT2: nxt = RD_PORT0;
            default:  nxt = RD_PORT0;
        endcase
        return nxt;
    endfunction

    function automatic logic [2:0] rd_port_onehot(input rd_port_id_t id);
        logic [2:0] oh;
        case (id)
            RD_PORT0: oh = 3'b001;
            RD_PORT1: oh = 3'b010;
            RD_PORT2: oh = 3'b100;
            default:  oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/sgpr_rr_pick3.sv
// Combinational 3-way picker: highest priority goes to last+1, then last+2, then last (mod 3).
// Tying last to port 2 yields fixed priority 0 > 1 > 2.
module sgpr_rr_pick3 (
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic [2:0] gnt,
    output logic [1:0] idx
);
    import sgpr_rd_arb_pkg::*;

    logic [3:0]  req_ext_s;
    rd_port_id_t p0_s;
    rd_port_id_t p1_s;
    rd_port_id_t p2_s;

    assign req_ext_s = {1'b0, req};

    // Walk the rotated priority order and take the first pending request.
    always_comb begin
        p0_s = rd_port_inc(last);
        p1_s = rd_port_inc(p0_s);
        p2_s = rd_port_inc(p1_s);
        gnt  = 3'b000;
        idx  = RD_PORT0;
        if (req_ext_s[p0_s]) begin
            gnt = rd_port_onehot(p0_s);
            idx = p0_s;
        end else if (req_ext_s[p1_s]) begin
            gnt = rd_port_onehot(p1_s);
            idx = p1_s;
        end else if (req_ext_s[p2_s]) begin
            gnt = rd_port_onehot(p2_s);
            idx = p2_s;
        end else begin
            gnt = 3'b000;
            idx = RD_PORT0;
        end
    end

endmodule

// File: rtl/sgpr_rd_port_arbiter.sv
// Shares the SGPR read port among three requesters with a req/gnt handshake and 2-cycle return.
// Define SGPR_RD_ARB_RR_EN for round-robin arbitration; otherwise fixed priority 0 > 1 > 2.
module sgpr_rd_port_arbiter
    import sgpr_rd_arb_pkg::*;
#(
    parameter int ADDR_W = SGPR_ADDR_W,
    parameter int DATA_W = SGPR_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              port0_rd_req,
    input  logic [ADDR_W-1:0] port0_rd_addr,
    output logic              port0_rd_gnt,
    output logic              port0_rd_valid,
    input  logic              port1_rd_req,
    input  logic [ADDR_W-1:0] port1_rd_addr,
    output logic              port1_rd_gnt,
    output logic              port1_rd_valid,
    input  logic              port2_rd_req,
    input  logic [ADDR_W-1:0] port2_rd_addr,
    output logic              port2_rd_gnt,
    output logic              port2_rd_valid,
    output logic [DATA_W-1:0] port_rd_data,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data
);

    logic [2:0]        req_s;
    logic [2:0]        pick_gnt_s;
    logic [2:0]        gnt_s;
    logic              any_gnt_s;
    rd_port_id_t       win_s;
    rd_port_id_t       last_sel_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic [2:0]        valid_vec_s;

    logic              rd_en_r;
    logic [ADDR_W-1:0] rd_addr_r;
    rd_port_id_t       id_q_r;
    logic              valid2_r;
    rd_port_id_t       id_q2_r;

    assign req_s = {port2_rd_req, port1_rd_req, port0_rd_req};

    sgpr_rr_pick3 u_pick (
        .req  (req_s),
        .last (last_sel_s),
        .gnt  (pick_gnt_s),
        .idx  (win_s)
    );

    // Grants are forced low while reset is asserted.
    always_comb begin
        gnt_s = 3'b000;
        if (rst_n) begin
            gnt_s = pick_gnt_s;
        end else begin
            gnt_s = 3'b000;
        end
    end

    assign any_gnt_s    = |gnt_s;
    assign port0_rd_gnt = gnt_s[0];
    assign port1_rd_gnt = gnt_s[1];
    assign port2_rd_gnt = gnt_s[2];

`ifdef SGPR_RD_ARB_RR_EN
    rd_port_id_t last_gnt_r;

    // Most recently granted port; reset to 2 so port 0 leads after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_r <= RD_PORT2;
        end else if (any_gnt_s) begin
            last_gnt_r <= win_s;
        end else begin
            last_gnt_r <= last_gnt_r;
        end
    end

    assign last_sel_s = last_gnt_r;
`else
    assign last_sel_s = RD_PORT2;
`endif

    // Winner's address mux.
    always_comb begin
        win_addr_s = {ADDR_W{1'b0}};
        case (win_s)
            RD_PORT0: win_addr_s = port0_rd_addr;
            RD_PORT1: win_addr_s = port1_rd_addr;
            RD_PORT2: win_addr_s = port2_rd_addr;
            default:  win_addr_s = {ADDR_W{1'b0}};
        endcase
    end

    // Issue stage: strobe and address to the array, winner id into the first id stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en_r   <= 1'b0;
            rd_addr_r <= {ADDR_W{1'b0}};
            id_q_r    <= RD_PORT0;
        end else if (any_gnt_s) begin
            rd_en_r   <= 1'b1;
            rd_addr_r <= win_addr_s;
            id_q_r    <= win_s;
        end else begin
            rd_en_r   <= 1'b0;
            rd_addr_r <= rd_addr_r;
            id_q_r    <= id_q_r;
        end
    end

    // Return stage: aligns the owner id with the array's one-cycle data latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid2_r <= 1'b0;
            id_q2_r  <= RD_PORT0;
        end else begin
            valid2_r <= rd_en_r;
            id_q2_r  <= id_q_r;
        end
    end

    // Decode the registered owner id into per-port valid pulses.
    always_comb begin
        valid_vec_s = 3'b000;
        if (valid2_r) begin
            valid_vec_s = rd_port_onehot(id_q2_r);
        end else begin
            valid_vec_s = 3'b000;
        end
    end

    assign rd_en          = rd_en_r;
    assign rd_addr        = rd_addr_r;
    assign port0_rd_valid = valid_vec_s[0];
    assign port1_rd_valid = valid_vec_s[1];
    assign port2_rd_valid = valid_vec_s[2];
    assign port_rd_data   = rd_data;

endmodule

// File: tb/tb_sgpr_rd_port_arbiter.sv
// Directed plus short random bench for sgpr_rd_port_arbiter with a queue-based scoreboard.
module tb_sgpr_rd_port_arbiter;
    import sgpr_rd_arb_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0, req1, req2;
    logic [8:0]   addr0, addr1, addr2;
    logic         gnt0, gnt1, gnt2;
    logic         val0, val1, val2;
    logic [127:0] port_rd_data;
    logic         rd_en;
    logic [8:0]   rd_addr;
    logic [127:0] rd_data = 128'h0;

    typedef struct {
        int         due;
        logic [1:0] port;
        logic [8:0] addr;
    } exp_t;

    exp_t       iss_q[$];
    exp_t       ret_q[$];
    int         cyc;
    int         total;
    int         bad;
    int         model_last;
    logic [8:0] last_addr;

    sgpr_rd_port_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .port0_rd_req   (req0),
        .port0_rd_addr  (addr0),
        .port0_rd_gnt   (gnt0),
        .port0_rd_valid (val0),
        .port1_rd_req   (req1),
        .port1_rd_addr  (addr1),
        .port1_rd_gnt   (gnt1),
        .port1_rd_valid (val1),
        .port2_rd_req   (req2),
        .port2_rd_addr  (addr2),
        .port2_rd_gnt   (gnt2),
        .port2_rd_valid (val2),
        .port_rd_data   (port_rd_data),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] data_of(input logic [8:0] a);
        logic [31:0] b;
        b = {23'd0, a} ^ 32'h5A3C_0000;
        return {b + 32'd3, b + 32'd2, b + 32'd1, b};
    endfunction

    // SGPR array model: data one cycle after the strobe.
    always @(posedge clk) begin
        rd_data <= rd_en ? data_of(rd_addr) : 128'h0;
    end

    function automatic logic [2:0] model_pick(input logic [2:0] r, input int last);
        for (int k = 1; k <= 3; k++) begin
            int p;
            p = (last + k) % 3;
            if (r[p]) return 3'b001 << p;
        end
        return 3'b000;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: check grants, push expectations, clock, then check issue and return.
    task automatic tick(input logic [2:0] exp_gnt);
        exp_t e;
        #1;
        chk("gnt", {125'd0, gnt2, gnt1, gnt0}, {125'd0, exp_gnt});
        if (exp_gnt != 3'b000) begin
            e.port = (exp_gnt == 3'b001) ? 2'd0 : (exp_gnt == 3'b010) ? 2'd1 : 2'd2;
            e.addr = (exp_gnt == 3'b001) ? addr0 : (exp_gnt == 3'b010) ? addr1 : addr2;
            e.due  = cyc + 1;
            iss_q.push_back(e);
            e.due  = cyc + 2;
            ret_q.push_back(e);
        end
        @(posedge clk);
        cyc++;
        #1;
        if (iss_q.size() > 0 && iss_q[0].due == cyc) begin
            e = iss_q.pop_front();
            chk("rd_en", {127'd0, rd_en}, 128'd1);
            chk("rd_addr", {119'd0, rd_addr}, {119'd0, e.addr});
            last_addr = e.addr;
        end else begin
            chk("rd_en_idle", {127'd0, rd_en}, 128'd0);
            chk("rd_addr_hold", {119'd0, rd_addr}, {119'd0, last_addr});
        end
        if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
            e = ret_q.pop_front();
            chk("valid", {125'd0, val2, val1, val0}, {125'd0, rd_port_onehot(e.port)});
            chk("data", port_rd_data, data_of(e.addr));
        end else begin
            chk("valid_idle", {125'd0, val2, val1, val0}, 128'd0);
        end
    endtask

    initial begin
        logic [2:0] e;
        logic [2:0] r;
        total = 0; bad = 0; cyc = 0; last_addr = 9'h000; model_last = 2;
        rst_n = 1'b0;
        req0 = 1'b1; req1 = 1'b1; req2 = 1'b1;
        addr0 = 9'h100; addr1 = 9'h101; addr2 = 9'h102;

        // Reset values with all requests pending.
        #2;
        chk("rst_gnt", {125'd0, gnt2, gnt1, gnt0}, 128'd0);
        chk("rst_rd_en", {127'd0, rd_en}, 128'd0);
        chk("rst_rd_addr", {119'd0, rd_addr}, 128'd0);
        chk("rst_valid", {125'd0, val2, val1, val0}, 128'd0);
        @(posedge clk);
        cyc++;
        #1;
        chk("rst_rd_en_edge", {127'd0, rd_en}, 128'd0);
        rst_n = 1'b1;

        // Full contention for 6 cycles.
        for (int i = 0; i < 6; i++) begin
`ifdef SGPR_RD_ARB_RR_EN
            tick(3'b001 << (i % 3));
`else
            tick(3'b001);
`endif
        end
        req0 = 1'b0;
        tick(3'b010);
        req1 = 1'b0;
        tick(3'b100);
        req2 = 1'b0;
        tick(3'b000);
        tick(3'b000);

        // Single port, one-cycle request.
        req1 = 1'b1; addr1 = 9'h05A;
        tick(3'b010);
        req1 = 1'b0;
        tick(3'b000);
        tick(3'b000);

        // Back-to-back grants to port 2 with a new address each cycle.
        req2 = 1'b1; addr2 = 9'h010;
        tick(3'b100);
        addr2 = 9'h011;
        tick(3'b100);
        addr2 = 9'h012;
        tick(3'b100);
        req2 = 1'b0;
        tick(3'b000);
        tick(3'b000);

        // Reset one cycle after a grant: the read is dropped.
        req0 = 1'b1; addr0 = 9'h0AB;
        tick(3'b001);
        req0 = 1'b1; req1 = 1'b1; req2 = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rd_en", {127'd0, rd_en}, 128'd0);
        chk("mid_rst_rd_addr", {119'd0, rd_addr}, 128'd0);
        iss_q.delete();
        ret_q.delete();
        last_addr = 9'h000;
        tick(3'b000);
        rst_n = 1'b1;
        tick(3'b001);
        model_last = 0;

        // Random request patterns against the priority model.
        for (int i = 0; i < 24; i++) begin
            r = 3'($urandom_range(0, 7));
            req0 = r[0]; req1 = r[1]; req2 = r[2];
            addr0 = 9'($urandom_range(0, 511));
            addr1 = 9'($urandom_range(0, 511));
            addr2 = 9'($urandom_range(0, 511));
`ifdef SGPR_RD_ARB_RR_EN
            e = model_pick(r, model_last);
            if (e == 3'b001) model_last = 0;
            else if (e == 3'b010) model_last = 1;
            else if (e == 3'b100) model_last = 2;
`else
            e = model_pick(r, 2);
`endif
            tick(e);
        end
        req0 = 1'b0; req1 = 1'b0; req2 = 1'b0;
        tick(3'b000);
        tick(3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
